// File: rtl/filter_ctrl_pkg.sv
// Shared types and widths for the filter cutoff controller.
// The FSM walks one state per clock from IDLE through SLEW and back.
package filter_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MUL_EG  = 3'd1,
      MUL_LFO = 3'd2,
      SUM     = 3'd3,
      MAP     = 3'd4,
      SLEW    = 3'd5
   } filter_ctrl_state_t;

   localparam int SUM_W  = 19;
   localparam int PROD_W = 34;

endpackage

// File: rtl/filter_cutoff_ctrl_mul17s.sv
// Registered 17x17 signed multiplier; the parent muxes its operands.
// Products appear one clock after the operands are presented.
module mul17s
   import filter_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [16:0]       i_a,
   input  logic signed [16:0]       i_b,
   output logic signed [PROD_W-1:0] o_p
);

   logic signed [PROD_W-1:0] r_p;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_p <= '0;
      end else begin
         r_p <= i_a * i_b;
      end
   end

   assign o_p = r_p;

endmodule

// File: rtl/filter_cutoff_ctrl.sv
// Turns cutoff, envelope and LFO control values into a slew-limited
// moving-average filter order, one computation per sample tick.
module filter_cutoff_ctrl
   import filter_ctrl_pkg::*;
#(
   parameter int ORDER_W   = 8,
   parameter int ORDER_MIN = 1,
   parameter int ORDER_MAX = 255,
   parameter int MAX_STEP  = 0
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_tick,
   input  logic [15:0]        cutoff_freq,
   input  logic [15:0]        eg_amount,
   input  logic [15:0]        envelope,
   input  logic [15:0]        modulation,
   input  logic [15:0]        mod_depth,
   input  logic               overrun_clr,
   output logic [ORDER_W-1:0] order_out,
   output logic               bypass,
   output logic               order_update,
   output logic               busy,
   output logic               overrun
);

   filter_ctrl_state_t r_state, w_next;

   logic [15:0]        r_cutoff, r_eg_amt, r_env, r_mod, r_depth;
   logic [15:0]        r_eg_term, r_sum;
   logic [ORDER_W-1:0] r_target, r_order;
   logic               r_bypass, r_update, r_overrun;

   logic               w_busy, w_latch, w_sel_lfo, w_sum_en, w_map_en, w_slew_en;
   logic signed [16:0] w_a, w_b;
   logic signed [PROD_W-1:0] w_p;
   logic [SUM_W-1:0]   w_sum;
   logic [15:0]        w_sum_sat;
   int                 w_raw, w_cur, w_tgt;
   logic [ORDER_W-1:0] w_target, w_new_order;
   logic               w_unused;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (sample_tick) w_next = MUL_EG;
         MUL_EG:  w_next = MUL_LFO;
         MUL_LFO: w_next = SUM;
         SUM:     w_next = MAP;
         MAP:     w_next = SLEW;
         SLEW:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_busy    = (r_state != IDLE);
      w_latch   = (r_state == IDLE) && sample_tick;
      w_sel_lfo = (r_state == MUL_LFO);
      w_sum_en  = (r_state == SUM);
      w_map_en  = (r_state == MAP);
      w_slew_en = (r_state == SLEW);
   end

   // One multiplier serves both terms: envelope product in MUL_EG, LFO product in MUL_LFO.
   assign w_a = w_sel_lfo ? $signed({r_mod[15], r_mod}) : $signed({1'b0, r_eg_amt});
   assign w_b = w_sel_lfo ? $signed({1'b0, r_depth})   : $signed({1'b0, r_env});

   mul17s u_mul (
      .clk   (clk),
      .reset (reset),
      .i_a   (w_a),
      .i_b   (w_b),
      .o_p   (w_p)
   );

   // In SUM the product register holds the LFO product; bits [32:16] are its floor >>> 16.
   assign w_sum = SUM_W'(r_cutoff) + SUM_W'(r_eg_term) + {{2{w_p[32]}}, w_p[32:16]};

   always_comb begin
      if (w_sum[SUM_W-1]) begin
         w_sum_sat = 16'h0000;
      end else if (|w_sum[SUM_W-2:16]) begin
         w_sum_sat = 16'hFFFF;
      end else begin
         w_sum_sat = w_sum[15:0];
      end
   end

   always_comb begin
      w_raw = ORDER_MAX - int'(r_sum[15:8]);
      if (w_raw < ORDER_MIN) begin
         w_target = ORDER_W'(ORDER_MIN);
      end else if (w_raw > ORDER_MAX) begin
         w_target = ORDER_W'(ORDER_MAX);
      end else begin
         w_target = ORDER_W'(w_raw);
      end
   end

   always_comb begin
      w_cur = int'(r_order);
      w_tgt = int'(r_target);
      w_new_order = r_target;
      if (MAX_STEP > 0) begin
         if (w_tgt > w_cur + MAX_STEP) begin
            w_new_order = ORDER_W'(w_cur + MAX_STEP);
         end else if (w_tgt + MAX_STEP < w_cur) begin
            w_new_order = ORDER_W'(w_cur - MAX_STEP);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cutoff  <= '0;
         r_eg_amt  <= '0;
         r_env     <= '0;
         r_mod     <= '0;
         r_depth   <= '0;
         r_eg_term <= '0;
         r_sum     <= '0;
         r_target  <= '0;
         r_order   <= ORDER_W'(ORDER_MIN);
         r_bypass  <= 1'b1;
         r_update  <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_latch) begin
            r_cutoff <= cutoff_freq;
            r_eg_amt <= eg_amount;
            r_env    <= envelope;
            r_mod    <= modulation;
            r_depth  <= mod_depth;
         end
         if (w_sel_lfo) begin
            r_eg_term <= w_p[31:16];
         end
         if (w_sum_en) begin
            r_sum <= w_sum_sat;
         end
         if (w_map_en) begin
            r_target <= w_target;
         end
         if (w_slew_en) begin
            r_order  <= w_new_order;
            r_bypass <= (r_eg_amt == 16'h0000);
         end
         r_update <= w_slew_en;
         // A dropped tick outranks a clear in the same cycle.
         if (sample_tick && w_busy) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign w_unused = ^{w_p[33], w_p[15:0], r_sum[7:0]};

   assign order_out    = r_order;
   assign bypass       = r_bypass;
   assign order_update = r_update;
   assign busy         = w_busy;
   assign overrun      = r_overrun;

endmodule
